// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
//
// Load-use hazard detection and EX-stage operand forwarding for a 5-stage
// in-order pipeline. The unit keeps a shadow record of what sits in EX and MEM
// and advances that record in lock-step with the pipeline.
//
// Ports
//   CLK          pipeline clock, all state updates on the rising edge
//   RST_N        asynchronous, active-low reset
//   ID_Valid     ID holds a real instruction (0 = bubble)
//   ID_R1/ID_R2  source register indices of the ID instruction
//   R1_Used      ID instruction actually reads rs1
//   R2_Used      ID instruction actually reads rs2
//   ID_Rd        destination register index of the ID instruction
//   ID_RegWrite  ID instruction writes rd
//   ID_MemRead   ID instruction is a load
//   Flush        kill ID and EX (taken branch, ecall/uret, interrupt)
//   Stall        combinational: hold PC and IF/ID, insert a bubble into EX
//   Fwd_A/Fwd_B  registered operand source for the instruction now in EX
//                00 = register file, 01 = EX/MEM ALU result,
//                10 = MEM/WB write-back data
//   Stall_Count  saturating count of load-use stall cycles since reset
// -----------------------------------------------------------------------------
module hazard_forward_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              ID_Valid,
    input  logic [REG_AW-1:0] ID_R1,
    input  logic [REG_AW-1:0] ID_R2,
    input  logic              R1_Used,
    input  logic              R2_Used,
    input  logic [REG_AW-1:0] ID_Rd,
    input  logic              ID_RegWrite,
    input  logic              ID_MemRead,
    input  logic              Flush,
    output logic              Stall,
    output logic [1:0]        Fwd_A,
    output logic [1:0]        Fwd_B,
    output logic [CNT_W-1:0]  Stall_Count
);

    // Shadow slots. The write-back slot is not stored: the register file is
    // write-before-read, so an instruction in WB never needs forwarding.
    // Likewise the MEM slot needs no load flag, because a load in MEM is
    // already served by the MEM/WB forwarding path without stalling.
    logic [REG_AW-1:0] ex_rd_reg;
    logic              ex_wr_reg;
    logic              ex_ld_reg;
    logic [REG_AW-1:0] mem_rd_reg;
    logic              mem_wr_reg;

    logic [1:0]        fwd_a_reg;
    logic [1:0]        fwd_b_reg;
    logic [CNT_W-1:0]  stall_count_reg;

    // Per-operand view of the ID instruction: index 0 = rs1, 1 = rs2.
    logic [REG_AW-1:0] op_idx  [2];
    logic [1:0]        op_used;
    logic [1:0]        ex_hit;
    logic [1:0]        mem_hit;
    logic [1:0]        fwd_next [2];

    assign op_idx[0]  = ID_R1;
    assign op_idx[1]  = ID_R2;
    assign op_used[0] = R1_Used;
    assign op_used[1] = R2_Used;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_op
            // wr is already cleared for rd==0, so x0 can never hit here.
            assign ex_hit[gi]  = op_used[gi] && ex_wr_reg  && (ex_rd_reg  == op_idx[gi]);
            assign mem_hit[gi] = op_used[gi] && mem_wr_reg && (mem_rd_reg == op_idx[gi]);
            // The EX producer is the younger one, so it wins over MEM.
            assign fwd_next[gi] = ex_hit[gi]  ? 2'b01 :
                                  mem_hit[gi] ? 2'b10 : 2'b00;
        end
    endgenerate

    // A load in EX cannot forward its data yet: hold ID for one cycle.
    assign Stall = ID_Valid && !Flush && ex_ld_reg && (|ex_hit);

    // ID advances into EX only when it is real, not flushed and not held.
    logic issue;
    assign issue = ID_Valid && !Flush && !Stall;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ex_rd_reg       <= '0;
            ex_wr_reg       <= 1'b0;
            ex_ld_reg       <= 1'b0;
            mem_rd_reg      <= '0;
            mem_wr_reg      <= 1'b0;
            fwd_a_reg       <= 2'b00;
            fwd_b_reg       <= 2'b00;
            stall_count_reg <= '0;
        end else begin
            // MEM always takes whatever EX held, bubble or not.
            mem_rd_reg <= ex_rd_reg;
            mem_wr_reg <= ex_wr_reg;

            if (issue) begin
                ex_rd_reg <= ID_Rd;
                ex_wr_reg <= ID_RegWrite && (ID_Rd != '0);
                ex_ld_reg <= ID_MemRead;
                fwd_a_reg <= fwd_next[0];
                fwd_b_reg <= fwd_next[1];
            end else begin
                ex_rd_reg <= '0;
                ex_wr_reg <= 1'b0;
                ex_ld_reg <= 1'b0;
                fwd_a_reg <= 2'b00;
                fwd_b_reg <= 2'b00;
            end

            // Stall is already masked by Flush, so a flushed hazard is not counted.
            if (Stall && (stall_count_reg != {CNT_W{1'b1}})) begin
                stall_count_reg <= stall_count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign Fwd_A       = fwd_a_reg;
    assign Fwd_B       = fwd_b_reg;
    assign Stall_Count = stall_count_reg;

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

    localparam int AW = 5;
    localparam int CW = 32;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          ID_Valid = 1'b0;
    logic [AW-1:0] ID_R1 = '0;
    logic [AW-1:0] ID_R2 = '0;
    logic          R1_Used = 1'b0;
    logic          R2_Used = 1'b0;
    logic [AW-1:0] ID_Rd = '0;
    logic          ID_RegWrite = 1'b0;
    logic          ID_MemRead = 1'b0;
    logic          Flush = 1'b0;
    logic          Stall;
    logic [1:0]    Fwd_A;
    logic [1:0]    Fwd_B;
    logic [CW-1:0] Stall_Count;

    always #5 CLK = ~CLK;

    hazard_forward_unit #(.REG_AW(AW), .CNT_W(CW)) dut (
        .CLK(CLK), .RST_N(RST_N), .ID_Valid(ID_Valid), .ID_R1(ID_R1), .ID_R2(ID_R2),
        .R1_Used(R1_Used), .R2_Used(R2_Used), .ID_Rd(ID_Rd), .ID_RegWrite(ID_RegWrite),
        .ID_MemRead(ID_MemRead), .Flush(Flush), .Stall(Stall), .Fwd_A(Fwd_A),
        .Fwd_B(Fwd_B), .Stall_Count(Stall_Count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    // history[0] = instruction now in EX, history[1] = instruction now in MEM.
    // An entry "produces" register r when it writes a non-zero rd equal to r.
    typedef struct {
        logic [AW-1:0] rd;
        bit            writes;
        bit            load;
    } instr_t;

    instr_t        history [2];
    logic [1:0]    m_fa, m_fb;
    logic [CW-1:0] m_cnt;

    function automatic int producer_age(logic [AW-1:0] r);
        for (int a = 0; a < 2; a++)
            if (history[a].writes && history[a].rd != '0 && history[a].rd == r)
                return a;
        return -1;
    endfunction

    function automatic logic [1:0] model_sel(logic [AW-1:0] r, logic used);
        int a;
        if (!used) return 2'b00;
        a = producer_age(r);
        if (a == 0) return 2'b01;
        if (a == 1) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit needs_load_data(logic [AW-1:0] r, logic used);
        return used && producer_age(r) == 0 && history[0].load;
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 2; a++) history[a] = '{rd: '0, writes: 1'b0, load: 1'b0};
        m_fa = 2'b00;
        m_fb = 2'b00;
        m_cnt = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One pipeline cycle. Called just after a falling edge; drives inputs,
    // checks the combinational stall, clocks, then checks registered outputs.
    task automatic step(input string name, input logic v, input logic [AW-1:0] r1,
                        input logic [AW-1:0] r2, input logic u1, input logic u2,
                        input logic [AW-1:0] rd, input logic rw, input logic ld,
                        input logic fl, output logic stalled);
        logic       exp_stall;
        logic [1:0] na, nb;
        ID_Valid = v; ID_R1 = r1; ID_R2 = r2; R1_Used = u1; R2_Used = u2;
        ID_Rd = rd; ID_RegWrite = rw; ID_MemRead = ld; Flush = fl;
        #1;
        exp_stall = v && !fl && (needs_load_data(r1, u1) || needs_load_data(r2, u2));
        na = model_sel(r1, u1);
        nb = model_sel(r2, u2);
        chk({name, ".stall"}, {31'd0, Stall}, {31'd0, exp_stall});
        @(posedge CLK);
        history[1] = history[0];
        if (v && !fl && !exp_stall) begin
            history[0] = '{rd: rd, writes: rw && rd != '0, load: ld};
            m_fa = na;
            m_fb = nb;
        end else begin
            history[0] = '{rd: '0, writes: 1'b0, load: 1'b0};
            m_fa = 2'b00;
            m_fb = 2'b00;
        end
        if (exp_stall && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1;
        #1;
        chk({name, ".fwd_a"}, {30'd0, Fwd_A}, {30'd0, m_fa});
        chk({name, ".fwd_b"}, {30'd0, Fwd_B}, {30'd0, m_fb});
        chk({name, ".count"}, Stall_Count, m_cnt);
        $display("step %-8s v=%0b r1=%0d(%0b) r2=%0d(%0b) rd=%0d rw=%0b ld=%0b fl=%0b -> stall=%0b fa=%0d fb=%0d cnt=%0d",
                 name, v, r1, u1, r2, u2, rd, rw, ld, fl, Stall, Fwd_A, Fwd_B, Stall_Count);
        stalled = exp_stall;
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        logic s;
        for (int i = 0; i < n; i++) step("idle", 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, s);
    endtask

    initial begin
        logic s;
        logic [AW-1:0] r1, r2, rd;
        logic u1, u2, rw, ld, v, fl;

        model_reset();
        #3;
        chk("reset.stall", {31'd0, Stall}, 32'd0);
        chk("reset.fwd_a", {30'd0, Fwd_A}, 32'd0);
        chk("reset.fwd_b", {30'd0, Fwd_B}, 32'd0);
        chk("reset.count", Stall_Count, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // 1: add x5,x1,x2 ; add x6,x5,x1 -> Fwd_A=01, no stall
        step("t1.add", 1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0, s);
        step("t1.use", 1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0, 0, s);
        idle(2);

        // 2: lw x5 ; sub x7,x1,x5 -> one stall, then Fwd_B=10
        step("t2.lw", 1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0, s);
        step("t2.sub", 1, 5'd1, 5'd5, 1, 1, 5'd7, 1, 0, 0, s);
        step("t2.sub2", 1, 5'd1, 5'd5, 1, 1, 5'd7, 1, 0, 0, s);
        idle(2);

        // 3: lw x5 ; addi x6,x5 ; writes/reads of x0 ; lw x0 then read x0
        step("t3.lw", 1, 5'd2, 5'd0, 1, 0, 5'd5, 1, 1, 0, s);
        step("t3.addi", 1, 5'd5, 5'd5, 1, 0, 5'd6, 1, 0, 0, s);
        step("t3.addi2", 1, 5'd5, 5'd5, 1, 0, 5'd6, 1, 0, 0, s);
        step("t3.wx0", 1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0, 0, s);
        step("t3.slli", 1, 5'd0, 5'd0, 1, 0, 5'd8, 1, 0, 0, s);
        step("t3.lwx0", 1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1, 0, s);
        step("t3.rdx0", 1, 5'd0, 5'd0, 1, 1, 5'd9, 1, 0, 0, s);
        idle(2);

        // 4: flush together with a load-use hazard
        step("t4.lw", 1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0, s);
        step("t4.flush", 1, 5'd5, 5'd0, 1, 0, 5'd7, 1, 0, 1, s);
        step("t4.after", 1, 5'd5, 5'd0, 1, 0, 5'd7, 1, 0, 0, s);
        idle(2);

        // 5: same rd twice back to back, then read -> newer (01)
        step("t5.w1", 1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0, s);
        step("t5.w2", 1, 5'd3, 5'd4, 1, 1, 5'd5, 1, 0, 0, s);
        step("t5.rd", 1, 5'd5, 5'd5, 1, 1, 5'd6, 1, 0, 0, s);
        idle(2);

        // 6: reset asserted mid-stall with a live forward select
        step("t6.add", 1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0, s);
        step("t6.lw", 1, 5'd5, 5'd0, 1, 0, 5'd6, 1, 1, 0, s);
        ID_Valid = 1; ID_R1 = 5'd6; ID_R2 = 5'd1; R1_Used = 1; R2_Used = 1;
        ID_Rd = 5'd7; ID_RegWrite = 1; ID_MemRead = 0; Flush = 0;
        #1;
        chk("t6.pre_stall", {31'd0, Stall}, 32'd1);
        chk("t6.pre_fwd_a", {30'd0, Fwd_A}, 32'd1);
        #1;
        RST_N = 1'b0;
        #1;
        model_reset();
        chk("t6.rst_stall", {31'd0, Stall}, 32'd0);
        chk("t6.rst_fwd_a", {30'd0, Fwd_A}, 32'd0);
        chk("t6.rst_fwd_b", {30'd0, Fwd_B}, 32'd0);
        chk("t6.rst_count", Stall_Count, 32'd0);
        $display("step t6.rst  stall=%0b fa=%0d fb=%0d cnt=%0d", Stall, Fwd_A, Fwd_B, Stall_Count);
        @(negedge CLK);
        RST_N = 1'b1;
        idle(1);

        // 7: saturated counter stays at all-ones through another stall
        force dut.stall_count_reg = {CW{1'b1}};
        #1;
        release dut.stall_count_reg;
        m_cnt = {CW{1'b1}};
        #1;
        chk("t7.preload", Stall_Count, m_cnt);
        step("t7.lw", 1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0, s);
        step("t7.use", 1, 5'd5, 5'd0, 1, 0, 5'd7, 1, 0, 0, s);
        step("t7.use2", 1, 5'd5, 5'd0, 1, 0, 5'd7, 1, 0, 0, s);

        // random traffic over a small register set so hazards are frequent;
        // a stalled instruction is re-presented the next cycle, as IF/ID holds it
        s = 1'b0;
        {v, r1, r2, u1, u2, rd, rw, ld} = '0;
        for (int i = 0; i < 400; i++) begin
            if (!s) begin
                v  = ($urandom_range(0, 9) != 0);
                r1 = AW'($urandom_range(0, 3));
                r2 = AW'($urandom_range(0, 3));
                u1 = $urandom_range(0, 3) != 0;
                u2 = $urandom_range(0, 1) != 0;
                rd = AW'($urandom_range(0, 3));
                rw = $urandom_range(0, 4) != 0;
                ld = $urandom_range(0, 2) == 0;
            end
            fl = ($urandom_range(0, 9) == 0);
            step("rand", v, r1, r2, u1, u2, rd, rw, ld, fl, s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
